dwconv_pe_grid: RTL

DWCONV_PE_GRID -- requirements
Module: dwconv_pe_grid

---
 rtl/dwconv_pkg.sv | 35 +++
 rtl/dwconv_pe.sv | 51 +++++
 rtl/dwconv_pe_grid.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dwconv_pkg.sv
// dwconv_pkg: shared definitions for the depthwise-convolution PE grid.
//   state_t   : controller states (IDLE, ACC, HOLD)
//   SAT_W     : working width of shift_sat; accumulators must not be wider
//   shift_sat : arithmetic right shift, then clamp to a signed dw-bit range
// Optional macro DWCONV_RELU_EN: negative shifted sums become 0 before the clamp.
package dwconv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    localparam int SAT_W = 128;

    function automatic logic signed [SAT_W-1:0] shift_sat(
        input logic signed [SAT_W-1:0] sum,
        input int unsigned             shift,
        input int unsigned             dw
    );
        logic signed [SAT_W-1:0] shifted;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        shifted = sum >>> shift;
`ifdef DWCONV_RELU_EN
        if (shifted < 0) shifted = '0;
`endif
        hi = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
        lo = ~hi;
        if (shifted > hi) return hi;
        if (shifted < lo) return lo;
        return shifted;
    endfunction

endpackage

// File: rtl/dwconv_pe.sv
// dwconv_pe: one processing element -- signed MAC plus window accumulator.
//   clk, rst : clock, asynchronous active-high reset
//   en       : an accepted tap beat is present
//   first    : the beat opens a new window (load instead of add)
//   pixel    : this PE's pixel for the beat
//   weight   : broadcast tap weight
//   shift    : window output shift (latched by the controller)
//   result   : shifted, saturated accumulator (combinational from acc)
module dwconv_pe
    import dwconv_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 40,
    parameter int SW = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 first,
    input  logic signed [DW-1:0] pixel,
    input  logic signed [DW-1:0] weight,
    input  logic        [SW-1:0] shift,
    output logic        [DW-1:0] result
);

    logic signed [2*DW-1:0]  prod;
    logic signed [AW-1:0]    prod_ext;
    logic signed [AW-1:0]    acc;
    logic signed [SAT_W-1:0] sat;

    assign prod     = pixel * weight;
    // Size cast of a signed operand sign-extends the full-width product.
    assign prod_ext = AW'(prod);

    // NOTE: non-blocking assignments in clocked blocks so every PE samples
    // the same pre-edge values regardless of evaluation order.
    // NOTE: the accumulator is an ordinary flop array, so it takes the async
    // reset; that is what makes result read 0 the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= first ? prod_ext : acc + prod_ext;
        end
    end

    // acc only changes on accepted beats, so result is stable while holding.
    assign sat    = shift_sat(SAT_W'(acc), 32'(shift), DW);
    assign result = DW'(sat);

endmodule

// File: rtl/dwconv_pe_grid.sv
// dwconv_pe_grid: POY x POX grid of depthwise-conv MAC PEs with one controller.
// A window is cfg_taps beats (0 -> 1, >MAX_TAPS -> MAX_TAPS); taps and shift
// are latched on the first beat. The finished window is held until out_ready.
//   clk, rst          : clock, asynchronous active-high reset
//   cfg_taps          : taps per window
//   cfg_shift         : arithmetic right shift before saturation
//   in_valid/in_ready : tap beat handshake
//   pixel_array       : one signed pixel per PE
//   weight            : signed tap weight broadcast to all PEs
//   out_valid/out_ready : result handshake
//   result            : shifted, saturated window sums
// Optional macro DWCONV_RELU_EN: clamp negative outputs to 0.
module dwconv_pe_grid
    import dwconv_pkg::*;
#(
    parameter int  DW       = 16,
    parameter int  AW       = 40,
    parameter int  POX      = 16,
    parameter int  POY      = 3,
    parameter int  MAX_TAPS = 9,
    localparam int TW       = $clog2(MAX_TAPS + 1),
    localparam int SW       = $clog2(AW)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [TW-1:0]                      cfg_taps,
    input  logic [SW-1:0]                      cfg_shift,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [POY-1:0][POX-1:0][DW-1:0]    pixel_array,
    input  logic [DW-1:0]                      weight,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [POY-1:0][POX-1:0][DW-1:0]    result
);

    generate
        if (AW < 2 * DW + $clog2(MAX_TAPS)) begin : g_aw_too_small
            $error("dwconv_pe_grid: AW must be >= 2*DW + clog2(MAX_TAPS)");
        end
        if (AW > SAT_W) begin : g_aw_too_large
            $error("dwconv_pe_grid: AW exceeds dwconv_pkg::SAT_W");
        end
    endgenerate

    state_t        state;
    logic [TW-1:0] tap_cnt;
    logic [TW-1:0] taps_q;
    logic [SW-1:0] shift_q;
    logic [TW-1:0] eff_taps;
    logic          beat;
    logic          first_beat;

    assign beat       = in_valid && in_ready;
    assign first_beat = (state == IDLE);

    // NOTE: default assignment first, so every path drives eff_taps and no
    // latch is inferred.
    always_comb begin
        eff_taps = cfg_taps;
        if (cfg_taps == '0) begin
            eff_taps = TW'(1);
        end else if (cfg_taps > TW'(MAX_TAPS)) begin
            eff_taps = TW'(MAX_TAPS);
        end
    end

    // in_ready / out_valid are registered alongside the state so they always
    // match it: in_ready high in IDLE/ACC, out_valid high only in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tap_cnt   <= '0;
            taps_q    <= TW'(1);
            shift_q   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        taps_q  <= eff_taps;
                        shift_q <= cfg_shift;
                        tap_cnt <= TW'(1);
                        if (eff_taps == TW'(1)) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (beat) begin
                        tap_cnt <= tap_cnt + TW'(1);
                        if (tap_cnt == taps_q - TW'(1)) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        tap_cnt   <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar y = 0; y < POY; y++) begin : g_row
            for (genvar x = 0; x < POX; x++) begin : g_col
                dwconv_pe #(
                    .DW(DW),
                    .AW(AW),
                    .SW(SW)
                ) u_pe (
                    .clk   (clk),
                    .rst   (rst),
                    .en    (beat),
                    .first (first_beat),
                    .pixel (pixel_array[y][x]),
                    .weight(weight),
                    .shift (shift_q),
                    .result(result[y][x])
                );
            end
        end
    endgenerate

endmodule
